lane_commit_collector: RTL
==========================

// Module: lane_commit_collector
// PURPOSE
//  Sits directly upstream of the vector reorder buffer and sources its commit request (I_Commit_Req).
//  - Tracks each issued vector instruction against the lane mask it was issued with.
//  - Collects per-lane completion pulses and releases one in-order commit pulse per instruction,
//    only after every enabled lane has reported.
// PARAMETERS
//  NUM_LANE   16  number of vector lanes reporting completion
//  NUM_ENTRY  16  in-flight instruction slots (power of two)
// PORTS
//  clock            in   1                    clock
//  reset            in   1                    synchronous, active-high reset
//  I_Issue          in   1                    allocate a slot for an issued instruction
//  I_Issue_No       in   issue_no_t           issue number of the instruction being allocated
//  I_En_Lane        in   NUM_LANE             lanes that must report completion
//  I_Lane_Done      in   NUM_LANE             per-lane completion pulse
//  I_Lane_No        in   NUM_LANE x issue_no_t  issue number each lane reports
//  I_Stall          in   1                    downstream cannot accept a commit this cycle
//  O_Commit_Req     out  1                    commit pulse, drives ROB I_Commit_Req
//  O_Commit_No      out  issue_no_t           issue number being committed
//  O_Full           out  1                    all slots occupied
//  O_Empty          out  1                    no slot occupied
//  O_Overflow       out  1                    sticky: I_Issue seen while full
//  O_Orphan         out  1                    sticky: done matched no valid slot, or lane not in mask
// BEHAVIOUR
//  - Reset: all slots invalid.
//    O_Commit_Req=0, O_Commit_No=0, O_Full=0, O_Empty=1, O_Overflow=0, O_Orphan=0.
//  - Allocate:
//    - I_Issue & ~Full writes slot[tail] = {v=1, issue_no, en_lane, done=0}; tail advances.
//    - I_Issue & Full drops the request and sets O_Overflow.
//  - Match: for each lane L with I_Lane_Done[L], compare I_Lane_No[L] to every valid slot issue_no.
//    - On a hit with en_lane[L]=1, set done[L].
//    - On a miss, or a hit with en_lane[L]=0, set O_Orphan and change no slot.
//    - A repeated done on a bit already set is ignored, with no error.
//  - Same-cycle issue+done: a done whose number equals I_Issue_No (when allocated) is merged
//    into the new slot's done mask.
//  - Issue numbers are unique within the window.
//  - Commit readiness: head is complete when v & ((done & en_lane) == en_lane).
//    - en_lane==0 counts as complete immediately.
//  - Commit pulse: O_Commit_Req = head complete & ~I_Stall & ~Empty.
//    - Combinational from registered state; O_Commit_No = slot[head].issue_no.
//    - On the same edge the head slot is invalidated and head advances.
//    - At most one commit per cycle, strictly in allocation order.
//  - Latency: last lane done in cycle t gives O_Commit_Req in cycle t+1 (unstalled).
//    - Same-cycle issue+done of an empty-mask or fully-merged entry: commit in t+1 if at head.
//  - Simultaneous allocate and commit with Full=1 in the same cycle:
//    - The allocate is refused, because Full is evaluated before the pop.
//  - Pointers wrap modulo NUM_ENTRY.
//  - Full/Empty come from the pointer controller, registered.
//  - Reset mid-operation: all state cleared on the next edge; in-flight done pulses that cycle
//    are discarded.
//  - I_Stall holds all slots; done pulses still accumulate while stalled.
// STRUCTURE
//  - pkg_tpu: typedef lane_commit_ent_t {v, issue_no_t issue_no, [NUM_LANE-1:0] en_lane,
//    [NUM_LANE-1:0] done}.
//  - Sub-module: RingBuffCTRL (NUM_ENTRY), driven with I_We=I_Issue&~Full, I_Re=O_Commit_Req.
//  - Per-slot match/merge logic is generated inline.
// TESTING
//  1. Issue No=5, En=0x0003; done lane0 (5), then lane1 (5) two cycles later
//     -> one O_Commit_Req, No=5, one cycle after the lane1 pulse.
//  2. Issue 1,2,3, all En=0x0001; lane0 done order 3,2,1
//     -> commits 1,2,3 in consecutive cycles after the "1" pulse.
//  3. Issue 16 entries, no done; issue a 17th
//     -> O_Full=1, 17th dropped, O_Overflow=1, head still entry 0.
//  4. Done lane2 for No=9 with no slot 9 valid, then done lane3 on slot 4 with En=0x0001
//     -> O_Orphan=1, no mask change, no commit.
//  5. Hold I_Stall=1 while head No=7 completes, release after 3 cycles
//     -> no pulse during stall, single pulse No=7 on release.
//  6. Issue No=11, En=0; in the same cycle pulse reset
//     -> after reset O_Empty=1, no commit; re-issue No=11, En=0 -> commit next cycle.

Source files
------------

// File: rtl/lane_commit_collector_pkg.sv
// Shared types and sizes for the lane commit collector.
package lane_commit_collector_pkg;
  localparam int NUM_LANE  = 16;
  localparam int NUM_ENTRY = 16;
  localparam int ISSUE_W   = 8;
  localparam int PTR_W     = $clog2(NUM_ENTRY);

  typedef logic [ISSUE_W-1:0]  issue_no_t;
  typedef logic [NUM_LANE-1:0] lane_mask_t;
  typedef logic [PTR_W-1:0]    ptr_t;

  // One in-flight instruction: lanes it waits on and lanes that have reported.
  typedef struct packed {
    logic       v;
    issue_no_t  issue_no;
    lane_mask_t en_lane;
    lane_mask_t done;
  } lane_commit_ent_t;

  // An entry is complete once every enabled lane has reported; an empty mask is complete at once.
  function automatic logic ent_complete(input lane_commit_ent_t e);
    return e.v && ((e.done & e.en_lane) == e.en_lane);
  endfunction
endpackage

// File: rtl/lane_commit_collector_if.sv
// Bus between the issue/lane side and the collector.
// Handshake: issue is a single-cycle request, taken only when full is low (otherwise dropped and
// flagged); lane_done bits are single-cycle pulses with no back-pressure; commit_req is a
// single-cycle pulse that the consumer must take, and the consumer holds it off with stall.
interface lane_commit_collector_if;
  import lane_commit_collector_pkg::*;

  logic                                 issue;
  issue_no_t                            issue_no;
  lane_mask_t                           en_lane;
  lane_mask_t                           lane_done;
  logic [NUM_LANE-1:0][ISSUE_W-1:0]     lane_no;
  logic                                 stall;
  logic                                 commit_req;
  issue_no_t                            commit_no;
  logic                                 full;
  logic                                 empty;
  logic                                 overflow;
  logic                                 orphan;

  modport master (
    output issue, issue_no, en_lane, lane_done, lane_no, stall,
    input  commit_req, commit_no, full, empty, overflow, orphan
  );

  modport slave (
    input  issue, issue_no, en_lane, lane_done, lane_no, stall,
    output commit_req, commit_no, full, empty, overflow, orphan
  );
endinterface

// File: rtl/lane_commit_collector_ring_ctrl.sv
// Ring buffer pointer controller: write/read pointers plus registered full/empty.
module lane_commit_collector_ring_ctrl #(
  parameter int NUM_ENTRY = 16,
  localparam int PTR_W    = $clog2(NUM_ENTRY)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  output logic [PTR_W-1:0] wptr,
  output logic [PTR_W-1:0] rptr,
  output logic             full,
  output logic             empty
);
  logic [PTR_W:0] count;
  logic [PTR_W:0] count_next;

  // Occupancy after this cycle's write/read.
  always_comb begin
    count_next = count;
    case ({we, re})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers wrap naturally because NUM_ENTRY is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (we) wptr <= wptr + 1'b1;
      if (re) rptr <= rptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (PTR_W+1)'(NUM_ENTRY));
      empty <= (count_next == '0);
    end
  end
endmodule

// File: rtl/lane_commit_collector.sv
// Collects per-lane completion pulses for issued vector instructions and releases
// one in-order commit pulse per instruction once all of its enabled lanes have reported.
module lane_commit_collector
  import lane_commit_collector_pkg::*;
(
  input logic                     clock,
  input logic                     reset,
  lane_commit_collector_if.slave  bus
);
  lane_commit_ent_t slot_q [NUM_ENTRY];
  lane_mask_t       slot_hit [NUM_ENTRY];
  lane_mask_t       new_hit;
  lane_mask_t       credited;
  ptr_t             head;
  ptr_t             tail;
  logic             full;
  logic             empty;
  logic             alloc;
  logic             commit_req;
  logic             orphan_evt;
  logic             overflow_q;
  logic             orphan_q;
  lane_commit_ent_t head_ent;

  // Full is the registered value, so an allocate in a full cycle is refused even if head pops.
  assign alloc = bus.issue & ~full;

  lane_commit_collector_ring_ctrl #(.NUM_ENTRY(NUM_ENTRY)) u_ring (
    .clock (clock),
    .reset (reset),
    .we    (alloc),
    .re    (commit_req),
    .wptr  (tail),
    .rptr  (head),
    .full  (full),
    .empty (empty)
  );

  for (genvar s = 0; s < NUM_ENTRY; s++) begin : g_slot
    // Lanes whose reported issue number matches this valid slot.
    always_comb begin
      slot_hit[s] = '0;
      for (int l = 0; l < NUM_LANE; l++) begin
        slot_hit[s][l] = bus.lane_done[l] & slot_q[s].v & (bus.lane_no[l] == slot_q[s].issue_no);
      end
    end
  end

  // Lanes reporting the number being allocated this cycle, merged into the new slot.
  always_comb begin
    new_hit = '0;
    for (int l = 0; l < NUM_LANE; l++) begin
      new_hit[l] = alloc & bus.lane_done[l] & (bus.lane_no[l] == bus.issue_no);
    end
  end

  // A done pulse is orphaned unless some slot (existing or new) both matches and enables that lane.
  always_comb begin
    credited = new_hit & bus.en_lane;
    for (int s = 0; s < NUM_ENTRY; s++) begin
      credited = credited | (slot_hit[s] & slot_q[s].en_lane);
    end
    orphan_evt = |(bus.lane_done & ~credited);
  end

  // Commit is combinational from registered state; the head pops on the same edge.
  always_comb begin
    head_ent   = slot_q[head];
    commit_req = ent_complete(head_ent) & ~bus.stall & ~empty;
  end

  // Slot storage: accumulate done bits, invalidate the committed head, write the new tail.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_ENTRY; s++) begin
        slot_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_ENTRY; s++) begin
        slot_q[s].done <= slot_q[s].done | (slot_hit[s] & slot_q[s].en_lane);
        if (commit_req && (ptr_t'(s) == head)) begin
          slot_q[s].v <= 1'b0;
        end
        if (alloc && (ptr_t'(s) == tail)) begin
          slot_q[s].v        <= 1'b1;
          slot_q[s].issue_no <= bus.issue_no;
          slot_q[s].en_lane  <= bus.en_lane;
          slot_q[s].done     <= new_hit & bus.en_lane;
        end
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      if (bus.issue & full) overflow_q <= 1'b1;
      if (orphan_evt)       orphan_q   <= 1'b1;
    end
  end

  assign bus.commit_req = commit_req;
  assign bus.commit_no  = head_ent.issue_no;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.overflow   = overflow_q;
  assign bus.orphan     = orphan_q;
endmodule
